unified_mem_arbiter: RTL
========================

// Module: unified_mem_arbiter
// PURPOSE
//   Shares one single-ported, variable-latency unified memory between the IF-stage fetch port
//   and the MEM-stage load/store port of the 5-stage pipeline. Serialises requests, applies
//   data-first priority with an anti-starvation guard, and drives stall requests to the hazard unit.
//   Sits between pipeline ports and the external memory model.
// PARAMETERS
//   ADDR_W        32  byte-address width
//   DATA_W        32  data width; byte-enable width is DATA_W/8
//   MAX_D_STREAK  4   consecutive D grants allowed while an I request waits (>=1)
// PORTS
//   clk       in   1         single clock, rising edge
//   reset     in   1         asynchronous, active-high
//   i_req     in   1         fetch request; held with i_addr until i_ack
//   i_addr    in   ADDR_W    fetch address
//   i_ack     out  1         one-cycle pulse: i_rdata valid
//   i_rdata   out  DATA_W    fetched word
//   d_req     in   1         load/store request; held with d_* until d_ack
//   d_we      in   1         1 = store
//   d_addr    in   ADDR_W    data address
//   d_wdata   in   DATA_W    store data
//   d_be      in   DATA_W/8  store byte enables
//   d_ack     out  1         one-cycle pulse: access complete, d_rdata valid for loads
//   d_rdata   out  DATA_W    load data
//   m_req     out  1         memory request; held until m_ack
//   m_we, m_addr, m_wdata, m_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered copy of granted request
//   m_ack     in   1         memory completion pulse, m_rdata valid same cycle
//   m_rdata   in   DATA_W    memory read data
//   if_stall  out  1         i_req & ~i_ack (combinational)
//   mem_stall out  1         d_req & ~d_ack (combinational)
// BEHAVIOUR
//   - Reset: state IDLE, streak=0; m_req, m_we, i_ack, d_ack = 0; m_addr/m_wdata/m_be/rdata = 0.
//   - FSM: IDLE, BUSY_I, BUSY_D, RESP. IDLE with request -> BUSY_x: register request onto m_*,
//     assert m_req next cycle. BUSY_x holds m_* stable until m_ack; on m_ack capture m_rdata,
//     drop m_req, -> RESP. RESP: pulse owner's ack for one cycle with captured data -> IDLE.
//   - Latency: req sampled at cycle t -> m_req at t+1 -> m_ack at t+1+L -> ack at t+2+L (L>=0
//     cycles of memory wait; m_ack may arrive the cycle m_req first rises). Owner's req must drop
//     or change the cycle after ack; IDLE re-arbitrates, so back-to-back accesses have >=1 idle cycle.
//   - Priority in IDLE: D wins if d_req and (~i_req or streak<MAX_D_STREAK); else I wins.
//   - streak: +1 on each D grant while i_req=1 (saturating at MAX_D_STREAK); cleared on I grant
//     or any IDLE cycle with i_req=0.
//   - Non-owner requests are ignored (no ack) until arbitration; its stall output stays high.
//   - m_ack outside BUSY_I/BUSY_D is ignored. Requester changing/dropping req before ack is a
//     protocol violation (assertion), not handled.
//   - Reset mid-transaction: immediate return to IDLE, m_req=0, no ack issued; memory shares reset.
//   - d_rdata/i_rdata hold last captured value between acks; only owner's output updates.
// STRUCTURE
//   - mem_arb_pkg: arb_state_e {IDLE,BUSY_I,BUSY_D,RESP}, arb_owner_e {OWN_I,OWN_D}, default widths.
//   - No sub-module; one FSM always_ff plus combinational grant logic. Instantiated at pipeline
//     level; if_stall/mem_stall feed hazard_if.
// TESTING
//   - I only, L=0: i_req@t addr 0x100, m_rdata 0x00000013 -> m_req@t+1, i_ack=1 @t+2, if_stall 1 until t+2.
//   - Store, L=3: d_we=1 addr 0x2004 wdata 0xDEADBEEF be 0xF -> m_* match @t+1, m_req held 4 cycles, d_ack @t+5.
//   - Simultaneous i_req/d_req in IDLE, streak=0 -> D granted first, I granted next arbitration; if_stall stays 1 throughout.
//   - Continuous d_req with i_req held, MAX_D_STREAK=4 -> exactly 4 D grants then 1 I grant; streak back to 0.
//   - Reset asserted while BUSY_D with m_req=1 -> m_req, d_ack, i_ack =0 asynchronously; late m_ack after reset ignored.
//   - Spurious m_ack in IDLE -> no ack to either side, state unchanged.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and default widths for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MAX_D_STREAK = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Generic request/ack memory port: the master issues req (held until ack), the slave returns ack + rdata.
interface unified_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  ack;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);

endinterface

// File: rtl/unified_mem_arbiter.sv
// Serialises fetch and load/store requests onto one variable-latency memory, data-first with a starvation guard.
// Latency: request sampled at t -> m_req at t+1 -> owner ack at t+2+L; losers stall with no ack until granted.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  i_bus,
  unified_mem_arbiter_if.slave  d_bus,
  unified_mem_arbiter_if.master m_bus,
  output logic                  if_stall,
  output logic                  mem_stall
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_e            state;
  arb_owner_e            owner;
  logic [STREAK_W-1:0]   streak;

  logic                  grant_d;
  logic                  grant_i;
  logic                  sel_we;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [DATA_W/8-1:0]   sel_be;

  always_comb begin
    grant_d   = d_bus.req && (!i_bus.req || (streak < STREAK_MAX));
    grant_i   = i_bus.req && !grant_d;
    sel_we    = grant_d ? d_bus.we    : i_bus.we;
    sel_addr  = grant_d ? d_bus.addr  : i_bus.addr;
    sel_wdata = grant_d ? d_bus.wdata : i_bus.wdata;
    sel_be    = grant_d ? d_bus.be    : i_bus.be;
  end

  assign if_stall  = i_bus.req & ~i_bus.ack;
  assign mem_stall = d_bus.req & ~d_bus.ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_I;
      streak      <= '0;
      m_bus.req   <= 1'b0;
      m_bus.we    <= 1'b0;
      m_bus.addr  <= '0;
      m_bus.wdata <= '0;
      m_bus.be    <= '0;
      i_bus.ack   <= 1'b0;
      i_bus.rdata <= '0;
      d_bus.ack   <= 1'b0;
      d_bus.rdata <= '0;
    end else begin
      i_bus.ack <= 1'b0;
      d_bus.ack <= 1'b0;
      unique case (state)
        IDLE: begin
          // A D grant with a waiting fetch implies streak < max, so no saturation check is needed.
          if (!i_bus.req || grant_i) begin
            streak <= '0;
          end else if (grant_d) begin
            streak <= streak + 1'b1;
          end
          if (grant_d || grant_i) begin
            state       <= grant_d ? BUSY_D : BUSY_I;
            owner       <= grant_d ? OWN_D : OWN_I;
            m_bus.req   <= 1'b1;
            m_bus.we    <= sel_we;
            m_bus.addr  <= sel_addr;
            m_bus.wdata <= sel_wdata;
            m_bus.be    <= sel_be;
          end
        end
        BUSY_I, BUSY_D: begin
          if (m_bus.ack) begin
            m_bus.req <= 1'b0;
            state     <= RESP;
            if (owner == OWN_D) begin
              d_bus.rdata <= m_bus.rdata;
              d_bus.ack   <= 1'b1;
            end else begin
              i_bus.rdata <= m_bus.rdata;
              i_bus.ack   <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Requesters must hold their request stable from grant through the ack cycle.
  a_i_hold: assert property (@(posedge clk) disable iff (reset)
    ((state == BUSY_I) || (state == RESP && owner == OWN_I)) |->
      (i_bus.req && $stable(i_bus.addr)));

  a_d_hold: assert property (@(posedge clk) disable iff (reset)
    ((state == BUSY_D) || (state == RESP && owner == OWN_D)) |->
      (d_bus.req && $stable(d_bus.we) && $stable(d_bus.addr) &&
       $stable(d_bus.wdata) && $stable(d_bus.be)));

  a_i_read_only: assert property (@(posedge clk) disable iff (reset)
    i_bus.req |-> !i_bus.we);

endmodule
